// File: rtl/nios_system_nios2_processor_mult_pkg.sv
// Shared types and constants for the sequential 16-bit-chunk multiplier.
package nios_system_nios2_processor_mult_pkg;

    localparam int unsigned CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Number of MUL cycles: all chunk pairs when the high word is needed,
    // otherwise only the pairs that land in the low word.
    function automatic int unsigned mult_iters(input int unsigned width, input bit high_en);
        int unsigned n;
        n = width / CHUNK;
        return high_en ? (n * n) : ((n * (n + 1)) / 2);
    endfunction

endpackage

// File: rtl/nios_system_nios2_processor_mult_16x16.sv
// Unsigned 16x16 -> 32 combinational multiplier, the only multiplier in the datapath.
module nios_system_nios2_processor_mult_16x16
    import nios_system_nios2_processor_mult_pkg::*;
(
    input  logic [CHUNK-1:0]   a_i,
    input  logic [CHUNK-1:0]   b_i,
    output logic [2*CHUNK-1:0] prod_c
);

    assign prod_c = (2*CHUNK)'(a_i) * (2*CHUNK)'(b_i);

endmodule

// File: rtl/nios_system_nios2_processor_mult_seq.sv
// Sequential multiplier: one 16x16 partial product per cycle into a
// double-width accumulator, followed by a signed-correction (FIX) cycle.
// Build option: NIOS2_MULT_SEQ_HIGH_EN enables high word and signed operands;
// without it only the low word is produced and FIX is an idle cycle.
module nios_system_nios2_processor_mult_seq
    import nios_system_nios2_processor_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sign1,
    input  logic             sign2,
    input  logic             high_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

`ifdef NIOS2_MULT_SEQ_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned IDX_W = 3;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic               sign1_q, sign1_d, sign2_q, sign2_d, high_q, high_d;
    logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [CHUNK-1:0]   a_chunk, b_chunk;
    logic [2*CHUNK-1:0] prod;
    logic [PW-1:0]      partial, fixed;
    logic               j_last, pair_last;

    // Chunk selection and the shifted partial product for the current pair.
    assign a_chunk = CHUNK'(src1_q >> (CHUNK * 32'(i_q)));
    assign b_chunk = CHUNK'(src2_q >> (CHUNK * 32'(j_q)));
    assign partial = PW'(prod) << (CHUNK * (32'(i_q) + 32'(j_q)));

    nios_system_nios2_processor_mult_16x16 u_mul (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .prod_c (prod)
    );

    // Inner-loop end: full row with high word, triangular (i+j < N) otherwise.
    assign j_last    = HIGH_EN ? (j_q == IDX_W'(N - 1)) : (j_q == (IDX_W'(N - 1) - i_q));
    assign pair_last = j_last && (i_q == IDX_W'(N - 1));

    // Two's-complement correction of the unsigned product.
    always_comb begin
        fixed = acc_q;
        if (HIGH_EN && sign1_q && src1_q[WIDTH-1]) fixed = fixed - {src2_q, WIDTH'(0)};
        if (HIGH_EN && sign2_q && src2_q[WIDTH-1]) fixed = fixed - {src1_q, WIDTH'(0)};
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (pair_last) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        src1_d   = src1_q;
        src2_d   = src2_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        high_d   = high_q;
        i_d      = i_q;
        j_d      = j_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    src1_d  = src1;
                    src2_d  = src2;
                    sign1_d = sign1;
                    sign2_d = sign2;
                    high_d  = high_sel;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            MUL: begin
                acc_d = acc_q + partial;
                if (j_last) begin
                    j_d = '0;
                    i_d = i_q + IDX_W'(1);
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            FIX: begin
                result_d = (HIGH_EN && high_q) ? fixed[PW-1:WIDTH] : fixed[WIDTH-1:0];
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src1_q   <= '0;
            src2_q   <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            high_q   <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            high_q   <= high_d;
            i_q      <= i_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_nios_system_nios2_processor_mult_seq.sv
// Directed bench for the sequential multiplier (WIDTH=32); adapts expectations
// to the NIOS2_MULT_SEQ_HIGH_EN build option.
module tb_nios_system_nios2_processor_mult_seq;

`ifdef NIOS2_MULT_SEQ_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
    localparam int K = 4;
`else
    localparam bit HIGH_EN = 1'b0;
    localparam int K = 3;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s1;
        logic        s2;
        logic        hs;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src1, src2;
    logic        sign1, sign2, high_sel;
    logic        busy, done;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_exp = 32'h0;

    always #5 clk = ~clk;

    nios_system_nios2_processor_mult_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src1     (src1),
        .src2     (src2),
        .sign1    (sign1),
        .sign2    (sign2),
        .high_sel (high_sel),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_of(input vec_t v);
        return (HIGH_EN && v.hs) ? v.hi : v.lo;
    endfunction

    // Issue one operation (called #1 after a rising edge) and follow it to done.
    // poke > 0 re-pulses start during that busy cycle index. Returns in the done cycle.
    task automatic do_op(input vec_t v, input string nm, input int poke);
        int idx;
        bit seen;
        logic [31:0] e;
        e = exp_of(v);
        start    = 1'b1;
        src1     = v.a;
        src2     = v.b;
        sign1    = v.s1;
        sign2    = v.s2;
        high_sel = v.hs;
        @(posedge clk); #1;
        start    = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
        sign1    = ~v.s1;
        sign2    = ~v.s2;
        high_sel = ~v.hs;
        idx  = 1;
        seen = 1'b0;
        chk({nm, "_hold"}, 64'(result), 64'(last_exp));
        while (!seen && idx <= 20) begin
            if (done) begin
                seen = 1'b1;
                chk({nm, "_lat"}, 64'(idx), 64'(K + 2));
                chk({nm, "_res"}, 64'(result), 64'(e));
                chk({nm, "_busy_at_done"}, 64'(busy), 64'(0));
            end else begin
                chk({nm, "_busy"}, 64'(busy), 64'(idx <= K + 1));
                start = (idx == poke);
                @(posedge clk); #1;
                idx++;
            end
        end
        start = 1'b0;
        if (!seen) chk({nm, "_timeout"}, 64'(0), 64'(1));
        last_exp = e;
    endtask

    vec_t vecs[10];

    initial begin
        int ndone;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000, 32'h00000001};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000001};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001};
        vecs[6] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'h00000000};
        vecs[7] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'h00000000};
        vecs[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 32'h0B00EA4E, 32'h242D2080};
        vecs[9] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};

        reset_n  = 1'b0;
        start    = 1'b0;
        src1     = '0;
        src2     = '0;
        sign1    = 1'b0;
        sign2    = 1'b0;
        high_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy),   64'(0));
        chk("rst_done",   64'(done),   64'(0));
        chk("rst_result", 64'(result), 64'(0));
        reset_n = 1'b1;

        // First edge after reset release must accept start.
        for (int i = 0; i < 10; i++) do_op(vecs[i], $sformatf("vec%0d", i), 0);

        // Start pulsed while busy is ignored; back-to-back start in done cycle.
        do_op(vecs[0], "poke", 2);
        do_op(vecs[8], "b2b", 0);
        ndone = 0;
        repeat (K + 4) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no_extra_done", 64'(ndone), 64'(0));
        chk("result_held", 64'(result), 64'(last_exp));

        // Abort mid-operation with reset.
        start    = 1'b1;
        src1     = 32'hFFFFFFFF;
        src2     = 32'hFFFFFFFF;
        sign1    = 1'b0;
        sign2    = 1'b0;
        high_sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("abort_busy",   64'(busy),   64'(0));
        chk("abort_done",   64'(done),   64'(0));
        chk("abort_result", 64'(result), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'(0));
        last_exp = 32'h0;
        do_op(vecs[6], "post_abort", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
